branch_ctrl: RTL and testbench

BRANCH_CTRL -- requirements
Module: branch_ctrl

---
 rtl/cpu_pkg.sv | 27 ++
 rtl/branch_cond.sv | 24 ++
 rtl/branch_ctrl.sv | 145 ++++++++++++++
 tb/tb_branch_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU definitions.
//   - Branch opcode encodings (BEQ/BLT/BGT/BNE)
//   - Branch-controller FSM state type
//   - Default flush length and flag-wait timeout
//   - is_branch_op(): true for any of the four branch opcodes
package cpu_pkg;

  localparam logic [4:0] OP_BEQ = 5'b10011;
  localparam logic [4:0] OP_BLT = 5'b10100;
  localparam logic [4:0] OP_BGT = 5'b10101;
  localparam logic [4:0] OP_BNE = 5'b10110;

  localparam int DEF_FLUSH_CYCLES = 2;
  localparam int DEF_TIMEOUT      = 255;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_FLAGS,
    ST_RESOLVE,
    ST_FLUSH
  } state_e;

  function automatic logic is_branch_op(input logic [4:0] op);
    return (op == OP_BEQ) || (op == OP_BLT) || (op == OP_BGT) || (op == OP_BNE);
  endfunction

endpackage

// File: rtl/branch_cond.sv
// branch_cond: combinational branch condition evaluator.
//   opcode [4:0] : branch opcode
//   flags  [1:0] : bit1 = Z (equal), bit0 = N (less-than)
//   taken        : 1 when the branch condition holds; 0 for non-branch opcodes
module branch_cond
  import cpu_pkg::*;
(
  input  logic [4:0] opcode,
  input  logic [1:0] flags,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (opcode)
      OP_BEQ:  taken = flags[1];
      OP_BNE:  taken = ~flags[1];
      OP_BLT:  taken = flags[0];
      OP_BGT:  taken = ~flags[0];
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_ctrl.sv
// branch_ctrl: branch resolution controller.
//   clk, rst_n (async, active-high despite the name)
//   br_valid/opcode/br_target : candidate branch from decode
//   flags/flags_valid          : ALU flags, captured whenever valid
//   flag_pending               : flags-producing instruction still in flight
//   stall, flush, pc_branch_sel, pc_target : pipeline control outputs
//   busy, timeout_err, taken_cnt, not_taken_cnt : status
module branch_ctrl
  import cpu_pkg::*;
#(
  parameter int PC_W         = 16,
  parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES,
  parameter int TIMEOUT      = DEF_TIMEOUT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            br_valid,
  input  logic [4:0]      opcode,
  input  logic [PC_W-1:0] br_target,
  input  logic [1:0]      flags,
  input  logic            flags_valid,
  input  logic            flag_pending,
  output logic            stall,
  output logic            flush,
  output logic            pc_branch_sel,
  output logic [PC_W-1:0] pc_target,
  output logic            busy,
  output logic            timeout_err,
  output logic [15:0]     taken_cnt,
  output logic [15:0]     not_taken_cnt
);

  localparam int WCW = $clog2(TIMEOUT + 1);
  localparam int FCW = $clog2(FLUSH_CYCLES + 1);

  state_e          state_q, state_d;
  logic [4:0]      opcode_q, opcode_d;
  logic [PC_W-1:0] target_q, target_d;
  logic [1:0]      flag_q, flag_d;
  logic [WCW-1:0]  wait_cnt_q, wait_cnt_d;
  logic [FCW-1:0]  flush_cnt_q, flush_cnt_d;
  logic            err_q, err_d;
  logic [15:0]     taken_q, taken_d;
  logic [15:0]     ntaken_q, ntaken_d;
  logic            cond_taken;

  branch_cond u_cond (
    .opcode (opcode_q),
    .flags  (flag_q),
    .taken  (cond_taken)
  );

  always_comb begin
    state_d       = state_q;
    opcode_d      = opcode_q;
    target_d      = target_q;
    wait_cnt_d    = wait_cnt_q;
    flush_cnt_d   = flush_cnt_q;
    err_d         = err_q;
    taken_d       = taken_q;
    ntaken_d      = ntaken_q;
    stall         = 1'b0;
    flush         = 1'b0;
    pc_branch_sel = 1'b0;
    // Capturing here in every state gives RESOLVE the same-cycle flags
    // when a branch is accepted together with flags_valid.
    flag_d        = flags_valid ? flags : flag_q;

    case (state_q)
      ST_IDLE: begin
        if (br_valid && is_branch_op(opcode)) begin
          opcode_d   = opcode;
          target_d   = br_target;
          wait_cnt_d = '0;
          state_d    = (flag_pending && !flags_valid) ? ST_WAIT_FLAGS : ST_RESOLVE;
        end
      end
      ST_WAIT_FLAGS: begin
        stall = 1'b1;
        if (flags_valid) begin
          state_d = ST_RESOLVE;
        end else if (wait_cnt_q == WCW'(TIMEOUT - 1)) begin
          // This is the TIMEOUT-th wait cycle: give up on the branch.
          err_d      = 1'b1;
          wait_cnt_d = '0;
          state_d    = ST_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + WCW'(1);
        end
      end
      ST_RESOLVE: begin
        stall = 1'b1;
        if (cond_taken) begin
          pc_branch_sel = 1'b1;
          taken_d       = taken_q + 16'd1;
          flush_cnt_d   = '0;
          state_d       = ST_FLUSH;
        end else begin
          ntaken_d = ntaken_q + 16'd1;
          state_d  = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        flush = 1'b1;
        if (flush_cnt_q == FCW'(FLUSH_CYCLES - 1)) begin
          state_d = ST_IDLE;
        end else begin
          flush_cnt_d = flush_cnt_q + FCW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q     <= ST_IDLE;
      opcode_q    <= '0;
      target_q    <= '0;
      flag_q      <= '0;
      wait_cnt_q  <= '0;
      flush_cnt_q <= '0;
      err_q       <= 1'b0;
      taken_q     <= '0;
      ntaken_q    <= '0;
    end else begin
      state_q     <= state_d;
      opcode_q    <= opcode_d;
      target_q    <= target_d;
      flag_q      <= flag_d;
      wait_cnt_q  <= wait_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      err_q       <= err_d;
      taken_q     <= taken_d;
      ntaken_q    <= ntaken_d;
    end
  end

  assign pc_target     = target_q;
  assign busy          = (state_q != ST_IDLE);
  assign timeout_err   = err_q;
  assign taken_cnt     = taken_q;
  assign not_taken_cnt = ntaken_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// tb_branch_ctrl: directed scenarios with literal expectations, plus a
// schedule-based reference model compared against the DUT every cycle.
module tb_branch_ctrl;

  localparam int PC_W    = 16;
  localparam int FLUSH_N = 2;
  localparam int TO      = 255;

  localparam logic [4:0] BEQ = 5'b10011;
  localparam logic [4:0] BLT = 5'b10100;
  localparam logic [4:0] BGT = 5'b10101;
  localparam logic [4:0] BNE = 5'b10110;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            br_valid = 1'b0;
  logic [4:0]      opcode = '0;
  logic [PC_W-1:0] br_target = '0;
  logic [1:0]      flags = '0;
  logic            flags_valid = 1'b0;
  logic            flag_pending = 1'b0;
  logic            stall, flush, pc_branch_sel, busy, timeout_err;
  logic [PC_W-1:0] pc_target;
  logic [15:0]     taken_cnt, not_taken_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_ctrl #(.PC_W(PC_W), .FLUSH_CYCLES(FLUSH_N), .TIMEOUT(TO)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .br_valid      (br_valid),
    .opcode        (opcode),
    .br_target     (br_target),
    .flags         (flags),
    .flags_valid   (flags_valid),
    .flag_pending  (flag_pending),
    .stall         (stall),
    .flush         (flush),
    .pc_branch_sel (pc_branch_sel),
    .pc_target     (pc_target),
    .busy          (busy),
    .timeout_err   (timeout_err),
    .taken_cnt     (taken_cnt),
    .not_taken_cnt (not_taken_cnt)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each cycle's expected outputs come from a queue of pre-planned cycles;
  // only the open-ended flag wait is tracked separately.
  typedef struct packed {
    logic stall;
    logic flush;
    logic sel;
    logic inc_t;
    logic inc_nt;
  } exp_t;

  function automatic exp_t mk(input logic s, input logic f, input logic p,
                              input logic it, input logic in_);
    exp_t e;
    e.stall = s; e.flush = f; e.sel = p; e.inc_t = it; e.inc_nt = in_;
    return e;
  endfunction

  exp_t            cur = '0;
  exp_t            sched[$];
  bit              waiting = 0;
  int              wait_n = 0;
  logic [1:0]      mflags = '0;
  logic [4:0]      m_op = '0;
  logic [15:0]     e_tc = '0;
  logic [15:0]     e_ntc = '0;
  logic [PC_W-1:0] e_target = '0;
  logic            e_err = 1'b0;

  function automatic bit rule_taken(input logic [4:0] op, input logic [1:0] f);
    if (op == BEQ) return f[1] == 1'b1;
    if (op == BNE) return f[1] == 1'b0;
    if (op == BLT) return f[0] == 1'b1;
    if (op == BGT) return f[0] == 1'b0;
    return 1'b0;
  endfunction

  function automatic bit is_br(input logic [4:0] op);
    return op == BEQ || op == BNE || op == BLT || op == BGT;
  endfunction

  task automatic m_resolve(input logic [1:0] f);
    bit t;
    t = rule_taken(m_op, f);
    cur = mk(1'b1, 1'b0, t, 1'b0, 1'b0);
    if (t) begin
      for (int i = 0; i < FLUSH_N; i++) sched.push_back(mk(1'b0, 1'b1, 1'b0, i == 0, 1'b0));
    end else begin
      sched.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst_n);
    if (rst_n) begin
      cur = '0; sched.delete(); waiting = 0; wait_n = 0; mflags = '0; m_op = '0;
      e_tc = '0; e_ntc = '0; e_target = '0; e_err = 1'b0;
    end else begin
      if (!(cur.stall || cur.flush)) begin
        cur = '0;
        if (br_valid && is_br(opcode)) begin
          m_op = opcode;
          e_target = br_target;
          if (flag_pending && !flags_valid) begin
            waiting = 1; wait_n = 0;
            cur = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
          end else begin
            m_resolve(flags_valid ? flags : mflags);
          end
        end
      end else if (waiting) begin
        if (flags_valid) begin
          waiting = 0;
          m_resolve(flags);
        end else begin
          wait_n++;
          if (wait_n == TO) begin
            waiting = 0; e_err = 1'b1; cur = '0;
          end
        end
      end else begin
        cur = (sched.size() > 0) ? sched.pop_front() : '0;
      end
      if (cur.inc_t) e_tc = e_tc + 16'd1;
      if (cur.inc_nt) e_ntc = e_ntc + 16'd1;
      if (flags_valid) mflags = flags;
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      check("m_stall", stall, cur.stall);
      check("m_flush", flush, cur.flush);
      check("m_sel", pc_branch_sel, cur.sel);
      check("m_busy", busy, cur.stall | cur.flush);
      check("m_target", pc_target, e_target);
      check("m_err", timeout_err, e_err);
      check("m_taken", taken_cnt, e_tc);
      check("m_ntaken", not_taken_cnt, e_ntc);
      check("m_sel_flush_excl", pc_branch_sel & flush, 0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    br_valid = 1'b0; opcode = '0; br_target = '0;
    flags = '0; flags_valid = 1'b0; flag_pending = 1'b0;
  endtask

  task automatic do_reset();
    idle_in();
    rst_n = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, k;
    bit saw_flush, saw_sel;

    // Reset values
    #1;
    check("rst_stall", stall, 0);
    check("rst_flush", flush, 0);
    check("rst_sel", pc_branch_sel, 0);
    check("rst_target", pc_target, 0);
    check("rst_busy", busy, 0);
    check("rst_err", timeout_err, 0);
    check("rst_tc", taken_cnt, 0);
    check("rst_ntc", not_taken_cnt, 0);
    do_reset();

    // BEQ with Z=1 in the flag register, no pending flags
    flags_valid = 1'b1; flags = 2'b10;
    tick();
    flags_valid = 1'b0;
    br_valid = 1'b1; opcode = BEQ; br_target = 16'h1234;
    tick();
    br_valid = 1'b0;
    check("s1_sel", pc_branch_sel, 1);
    check("s1_stall", stall, 1);
    check("s1_target", pc_target, 16'h1234);
    tick();
    check("s1_flush1", flush, 1);
    check("s1_flush1_stall", stall, 0);
    check("s1_tc", taken_cnt, 1);
    tick();
    check("s1_flush2", flush, 1);
    tick();
    check("s1_flush_end", flush, 0);
    check("s1_idle", busy, 0);

    // BGT taken then not taken, flags bypassed in the accept cycle
    do_reset();
    br_valid = 1'b1; opcode = BGT; br_target = 16'h00A0; flags_valid = 1'b1; flags = 2'b10;
    tick();
    br_valid = 1'b0; flags_valid = 1'b0;
    check("s2_first_sel", pc_branch_sel, 1);
    tick(); tick(); tick();
    br_valid = 1'b1; opcode = BGT; br_target = 16'h00B0; flags_valid = 1'b1; flags = 2'b01;
    tick();
    br_valid = 1'b0; flags_valid = 1'b0;
    check("s2_second_sel", pc_branch_sel, 0);
    check("s2_second_stall", stall, 1);
    tick();
    check("s2_tc", taken_cnt, 1);
    check("s2_ntc", not_taken_cnt, 1);
    check("s2_no_flush", flush, 0);

    // BNE waiting on pending flags that arrive 3 cycles later with Z=1
    do_reset();
    br_valid = 1'b1; opcode = BNE; br_target = 16'h0C00; flag_pending = 1'b1;
    tick();
    br_valid = 1'b0;
    n = 0; saw_flush = 0; saw_sel = 0;
    for (int c = 1; c <= 5; c++) begin
      if (c == 3) begin flags_valid = 1'b1; flags = 2'b11; end
      if (stall) n++;
      if (flush) saw_flush = 1;
      if (pc_branch_sel) saw_sel = 1;
      tick();
      if (c == 3) begin flags_valid = 1'b0; flag_pending = 1'b0; end
    end
    check("s3_stall_cycles", n, 4);
    check("s3_no_flush", saw_flush, 0);
    check("s3_no_sel", saw_sel, 0);
    check("s3_ntc", not_taken_cnt, 1);
    check("s3_tc", taken_cnt, 0);

    // BLT with flags never arriving -> timeout
    do_reset();
    br_valid = 1'b1; opcode = BLT; br_target = 16'h0777; flag_pending = 1'b1;
    tick();
    br_valid = 1'b0;
    n = 0; k = 0;
    while (!timeout_err && k < 300) begin
      if (stall) n++;
      k++;
      tick();
    end
    check("s4_wait_cycles", n, 255);
    check("s4_err", timeout_err, 1);
    check("s4_idle", busy, 0);
    check("s4_tc", taken_cnt, 0);
    check("s4_ntc", not_taken_cnt, 0);
    flag_pending = 1'b0;
    tick();
    check("s4_err_sticky", timeout_err, 1);

    // Reset asserted mid-FLUSH, then a fresh BEQ
    do_reset();
    br_valid = 1'b1; opcode = BEQ; br_target = 16'h5A5A; flags_valid = 1'b1; flags = 2'b10;
    tick();
    br_valid = 1'b0; flags_valid = 1'b0;
    tick();
    check("s5_in_flush", flush, 1);
    #2 rst_n = 1'b1;
    #1;
    check("s5_rst_flush", flush, 0);
    check("s5_rst_stall", stall, 0);
    check("s5_rst_sel", pc_branch_sel, 0);
    check("s5_rst_busy", busy, 0);
    check("s5_rst_target", pc_target, 0);
    check("s5_rst_tc", taken_cnt, 0);
    tick();
    rst_n = 1'b0;
    tick();
    br_valid = 1'b1; opcode = BEQ; br_target = 16'h0042; flags_valid = 1'b1; flags = 2'b10;
    tick();
    br_valid = 1'b0; flags_valid = 1'b0;
    check("s5_new_sel", pc_branch_sel, 1);
    check("s5_new_target", pc_target, 16'h0042);
    tick();
    check("s5_new_tc", taken_cnt, 1);
    tick(); tick();

    // Non-branch opcode, then a branch presented during FLUSH
    do_reset();
    br_valid = 1'b1; opcode = 5'b00001; br_target = 16'hDEAD; flags_valid = 1'b1; flags = 2'b10;
    tick();
    br_valid = 1'b0; flags_valid = 1'b0;
    check("s6_nonbranch_idle", busy, 0);
    tick();
    br_valid = 1'b1; opcode = BEQ; br_target = 16'h0100;
    tick();
    br_valid = 1'b0;
    check("s6_sel", pc_branch_sel, 1);
    tick();
    br_valid = 1'b1; opcode = BEQ; br_target = 16'hFFFF;
    check("s6_flush1", flush, 1);
    tick();
    check("s6_flush2", flush, 1);
    tick();
    br_valid = 1'b0;
    check("s6_idle", busy, 0);
    check("s6_target", pc_target, 16'h0100);
    check("s6_tc", taken_cnt, 1);
    check("s6_ntc", not_taken_cnt, 0);
    tick();
    check("s6_still_idle", busy, 0);

    idle_in();
    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
